modexp_ctrl_param: RTL
======================

Name: modexp_ctrl_param

Overview:
Parametrised control sequencer for Montgomery-ladder-free right-to-left binary modular exponentiation (RSA datapath).
- Drives the Montgomery multiplier (MMM) reset, operand/result load strobes, register write-enables and datapath muxes.
- Runs three phases: pre-conversion into the Montgomery domain, one slot per exponent bit, post-conversion out of the domain.
- Generalises the fixed-schedule control unit with:
  - configurable exponent width and MMM latency;
  - a start/busy/eoc handshake;
  - an abort input;
  - an optional leading-zero-skip mode.

Parameters:
EXP_W, 8, exponent width in bits (>=1).
MMM_LAT, 10, MMM compute cycles per multiplication (>=1); slot length SLOT = MMM_LAT+2.
SKIP_LZ, 0, 1 = terminate the bit loop after the highest set exponent bit; 0 = always run EXP_W loop slots.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
en  in  1  clock enable; 0 freezes all state and outputs.
start  in  1  begin exponentiation; sampled in IDLE only.
abort  in  1  synchronous cancel; return to IDLE.
exp_e  in  EXP_W  exponent; captured on accepted start.
rst_mmm  out  1  MMM clear, active-low.
ld_a  out  1  load MMM operand registers.
ld_r  out  1  capture MMM result.
lock1  out  1  write-enable of R register on ld_r.
lock2  out  1  write-enable of A register on ld_r.
sel1  out  2  operand mux: 00 pre, 01 loop, 10 post.
sel2  out  1  0 pre, 1 loop/post.
eoc  out  1  one-cycle end-of-computation pulse.
busy  out  1  high from the cycle after start acceptance through the eoc cycle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - rst_mmm=0, ld_a=0, ld_r=0, lock1=0, lock2=0, sel1=00, sel2=0, eoc=0, busy=0.
  - State=IDLE, counters=0, exponent shift register=0.
- Output timing: all outputs registered.
- en=0: every register holds, including outputs. en=1 is required for any transition, start, or abort.
- States: IDLE, PRE, LOOP, POST, DONE.
- Slot structure: slot counter c = 0..SLOT-1, used in PRE, LOOP and POST.
  - c=0: rst_mmm=0, ld_a=1.
  - c=1..MMM_LAT: rst_mmm=1, ld_a=0, ld_r=0.
  - c=SLOT-1: rst_mmm=1, ld_r=1.
- Start acceptance:
  - IDLE with start=1 at edge E0: capture exp_e, enter PRE.
  - The cycle after E0 is PRE c=0.
  - start is ignored in every other state.
- PRE: sel1=00, sel2=0, lock1=1, lock2=1. After c=SLOT-1:
  - go to LOOP;
  - if SKIP_LZ=1 and the captured exponent is 0, go to POST instead.
- LOOP, bit i (LSB first):
  - sel1=01, sel2=1, lock2=1, lock1=e_reg[0] for the whole slot.
  - At c=SLOT-1: shift e_reg right by 1 (zero fill) and increment bit counter.
  - Leave to POST when the bit counter reaches EXP_W, or when SKIP_LZ=1 and the shifted e_reg==0.
- POST: sel1=10, sel2=1, lock1=1, lock2=0. After c=SLOT-1, go to DONE.
- DONE: lasts one cycle.
  - eoc=1, busy=1, all strobes 0, rst_mmm=1, lock1=lock2=0.
  - Then IDLE.
- IDLE outputs equal the reset values.
- Latency:
  - N = 2 + loop count, where loop count is EXP_W, or floor(log2 e)+1 with SKIP_LZ=1 (0 for e=0).
  - eoc occupies cycle index N*SLOT after E0, with the cycle after E0 counted as index 0.
- abort=1 with en=1 in any non-IDLE state: next edge to IDLE with reset-value outputs, no eoc. abort has priority over every transition.
- Exponent input: exp_e changes after acceptance have no effect.
- Counter widths:
  - slot counter: clog2(SLOT);
  - bit counter: clog2(EXP_W+1).
  - Neither counter wraps within a run.
- Reset mid-operation: immediate reset values; the next start behaves as the first start.

Test Plan:
1. EXP_W=8, MMM_LAT=10, SKIP_LZ=0, exp_e=0x0B, start pulse:
   - busy rises at index 0; 10 slots of 12; eoc=1 at index 120 only;
   - lock1 per loop slot = 1,1,0,1,0,0,0,0; sel1 sequence 00 / 01 x8 / 10.
2. SKIP_LZ=1, exp_e=0x0B: 4 loop slots, eoc at index 72; exp_e=0x80 gives 8 loop slots, eoc at index 120.
3. SKIP_LZ=1, exp_e=0: PRE then POST directly; sel1 never 01; eoc at index 24.
4. en=0 for 5 cycles during LOOP c=3: all outputs and counters held; eoc at index 125.
5. abort at LOOP slot 2 c=5 -> next cycle reset values, busy=0, no eoc. Then rst pulse mid-PRE -> immediate reset values. A fresh start then reproduces scenario 1 exactly.
6. start re-asserted while busy and exp_e changed after E0 -> no restart; lock1 pattern matches the originally captured exponent.

Source files
------------

// File: rtl/modexp_ctrl_param.sv
// Control sequencer for right-to-left binary modular exponentiation.
// Drives the Montgomery multiplier in PRE / LOOP / POST slots with start/busy/eoc handshake.
module modexp_ctrl_param #(
  parameter int EXP_W   = 8,
  parameter int MMM_LAT = 10,
  parameter int SKIP_LZ = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] exp_e,
  output logic             rst_mmm,
  output logic             ld_a,
  output logic             ld_r,
  output logic             lock1,
  output logic             lock2,
  output logic [1:0]       sel1,
  output logic             sel2,
  output logic             eoc,
  output logic             busy
);

  localparam int SLOT = MMM_LAT + 2;
  localparam int CW   = $clog2(SLOT);
  localparam int BW   = $clog2(EXP_W + 1);

  localparam logic [CW-1:0] C_LAST = CW'(SLOT - 1);
  localparam logic [BW-1:0] B_END  = BW'(EXP_W);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LOOP,
    POST,
    DONE
  } state_t;

  state_t           state, nx_state;
  logic [CW-1:0]    c, nx_c;
  logic [BW-1:0]    bc, nx_bc;
  logic [EXP_W-1:0] e_reg, nx_e;

  logic       nx_rst_mmm;
  logic       nx_ld_a;
  logic       nx_ld_r;
  logic       nx_lock1;
  logic       nx_lock2;
  logic [1:0] nx_sel1;
  logic       nx_sel2;
  logic       nx_eoc;
  logic       nx_busy;

  logic slot_last;

  assign slot_last = (c == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c       <= '0;
      bc      <= '0;
      e_reg   <= '0;
      rst_mmm <= 1'b0;
      ld_a    <= 1'b0;
      ld_r    <= 1'b0;
      lock1   <= 1'b0;
      lock2   <= 1'b0;
      sel1    <= 2'b00;
      sel2    <= 1'b0;
      eoc     <= 1'b0;
      busy    <= 1'b0;
    end else if (en) begin
      state   <= nx_state;
      c       <= nx_c;
      bc      <= nx_bc;
      e_reg   <= nx_e;
      rst_mmm <= nx_rst_mmm;
      ld_a    <= nx_ld_a;
      ld_r    <= nx_ld_r;
      lock1   <= nx_lock1;
      lock2   <= nx_lock2;
      sel1    <= nx_sel1;
      sel2    <= nx_sel2;
      eoc     <= nx_eoc;
      busy    <= nx_busy;
    end
  end

  // Next state, slot counter, bit counter and exponent shifter
  always_comb begin
    nx_state = state;
    nx_c     = c;
    nx_bc    = bc;
    nx_e     = e_reg;
    unique case (state)
      IDLE: begin
        if (start) begin
          nx_state = PRE;
          nx_c     = '0;
          nx_bc    = '0;
          nx_e     = exp_e;
        end
      end
      PRE: begin
        if (slot_last) begin
          nx_c = '0;
          if (SKIP_LZ != 0 && e_reg == '0) nx_state = POST;
          else nx_state = LOOP;
        end else begin
          nx_c = c + 1'b1;
        end
      end
      LOOP: begin
        if (slot_last) begin
          nx_c  = '0;
          nx_e  = e_reg >> 1;
          nx_bc = bc + 1'b1;
          if (nx_bc == B_END ||
              (SKIP_LZ != 0 && nx_e == '0))
            nx_state = POST;
        end else begin
          nx_c = c + 1'b1;
        end
      end
      POST: begin
        if (slot_last) begin
          nx_c     = '0;
          nx_state = DONE;
        end else begin
          nx_c = c + 1'b1;
        end
      end
      DONE: begin
        nx_state = IDLE;
        nx_c     = '0;
        nx_bc    = '0;
      end
      default: begin
        nx_state = IDLE;
      end
    endcase
    if (abort && state != IDLE) begin
      nx_state = IDLE;
      nx_c     = '0;
      nx_bc    = '0;
      nx_e     = '0;
    end
  end

  // Outputs are registered, so decode them from the state being entered
  always_comb begin
    nx_rst_mmm = 1'b0;
    nx_ld_a    = 1'b0;
    nx_ld_r    = 1'b0;
    nx_lock1   = 1'b0;
    nx_lock2   = 1'b0;
    nx_sel1    = 2'b00;
    nx_sel2    = 1'b0;
    nx_eoc     = 1'b0;
    nx_busy    = 1'b0;
    unique case (nx_state)
      PRE, LOOP, POST: begin
        nx_busy    = 1'b1;
        nx_rst_mmm = (nx_c != '0);
        nx_ld_a    = (nx_c == '0);
        nx_ld_r    = (nx_c == C_LAST);
        unique case (1'b1)
          nx_state == PRE: begin
            nx_lock1 = 1'b1;
            nx_lock2 = 1'b1;
          end
          nx_state == LOOP: begin
            nx_sel1  = 2'b01;
            nx_sel2  = 1'b1;
            nx_lock1 = nx_e[0];
            nx_lock2 = 1'b1;
          end
          default: begin
            nx_sel1  = 2'b10;
            nx_sel2  = 1'b1;
            nx_lock1 = 1'b1;
          end
        endcase
      end
      DONE: begin
        nx_busy    = 1'b1;
        nx_eoc     = 1'b1;
        nx_rst_mmm = 1'b1;
      end
      default: begin
        nx_busy = 1'b0;
      end
    endcase
  end

endmodule
